ram_wbh: RTL and testbench
==========================

Name: ram_wbh

Overview:
- Byte-addressable data RAM with word (32 bit), half-word (16 bit) and byte accesses, little-endian.
- Separate independent read and write ports.
- Asynchronous (combinational) read; synchronous write on the rising clock edge.
- Flags misaligned accesses per port. Serves as the CPU data memory and reports alignment exceptions to the core.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored. Must be a power of two.
- AW, 8, word-index width, equal to log2(DEPTH_WORDS).

Ports:
- CLK  input  1  system clock; all writes on the rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- WE  input  1  write enable.
- RWHBS  input  2  read size: 11 = word, 01 = half, 00 = byte, 10 = word.
- WWHBS  input  2  write size, same encoding as RWHBS.
- RADDR  input  32  read byte address.
- WADDR  input  32  write byte address.
- DIN  input  32  write data; the low bits are used for half and byte writes.
- DOUT  output  32  read data, right-justified.
- RUnalExc  output  1  read misalignment flag, combinational.
- WUnalExc  output  1  write misalignment flag, combinational.

Behaviour:
- Storage: DEPTH_WORDS x 32 bits as four byte lanes.
  - Word index = ADDR[AW+1:2].
  - Lane = ADDR[1:0]; byte lane 0 maps to bits 7:0 (little-endian).
  - Address bits above AW+1 are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Reset: RSTn low asynchronously clears every word to 0. While RSTn is low, writes are blocked.
- Alignment (both ports):
  - Word access requires ADDR[1:0] = 00.
  - Half access requires ADDR[0] = 0.
  - Byte access is always aligned.
  - RUnalExc / WUnalExc = 1 for a misaligned access. The flags are purely combinational from address and size; WUnalExc does not depend on WE.
- Write: on posedge CLK with WE = 1, RSTn = 1 and WUnalExc = 0:
  - word: writes DIN[31:0] to the addressed word.
  - half: writes DIN[15:0] to lanes {ADDR[1]*2+1, ADDR[1]*2}; other lanes unchanged.
  - byte: writes DIN[7:0] to lane ADDR[1:0]; other lanes unchanged.
  - A misaligned write modifies nothing.
- Read: combinational from RADDR/RWHBS and current contents.
  - word: full word.
  - half: selected half, zero-extended.
  - byte: selected byte, zero-extended.
  - Misaligned read: DOUT = 0 and RUnalExc = 1.
  - During reset, DOUT reads 0.
- Same-address read and write in one cycle: DOUT shows the old data until the clock edge and the new data after it. There is no internal forwarding.
- Read and write ports operate fully independently; no hazards are reported.
- Latency: write takes effect at the first rising edge; read has zero cycles of latency.

Optional Feature:
- Macro RAM_SIGNEXT_EN.
- Defined: half and byte reads are sign-extended from bit 15 or bit 7 respectively.
- Undefined: half and byte reads are zero-extended (default).
- Word reads, misaligned behaviour and flags are identical in both builds.

Test Plan:
- Reset then word read: RSTn pulse low, release; read word at 0 -> DOUT = 0x00000000, RUnalExc = 0.
- Word and half writes:
  - Write word 0x11111111 at 0, half 0x22222222 at 4, half 0x33333333 at 6.
  - Word read at 0 -> 0x11111111; word read at 4 -> 0x33332222.
  - Half read at 4 -> 0x00002222; half read at 6 -> 0x00003333.
- Byte writes: write bytes 0x44444444, 0x55555555, 0x66666666, 0x77777777 at addresses 8, 9, 10, 11.
  - Word read at 8 -> 0x77665544.
  - Half read at 8 -> 0x00005544; half read at 10 -> 0x00007766.
  - Byte read at 10 -> 0x00000066.
- Misaligned read: half read at 5 -> RUnalExc = 1, DOUT = 0; word read at 6 -> RUnalExc = 1.
- Misaligned write: word write 0xDEADBEEF at 2 with WE = 1 -> WUnalExc = 1; words at 0 and 4 unchanged.
- Gating and build options:
  - WE = 0 with a valid address leaves memory unchanged.
  - With RAM_SIGNEXT_EN, a byte write of 0x80 then byte read -> 0xFFFFFF80; without it -> 0x00000080.

Source files
------------

// File: rtl/ram_wbh.sv
// Byte-addressable data RAM: word/half/byte access, little-endian, async read, sync write.
// Define RAM_SIGNEXT_EN to sign-extend half and byte reads (zero-extended otherwise).

module ram_wbh_lane #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // Async reset clears the lane, which also blocks writes while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

module ram_wbh #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        WE,
    input  logic [1:0]  RWHBS,
    input  logic [1:0]  WWHBS,
    input  logic [31:0] RADDR,
    input  logic [31:0] WADDR,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        RUnalExc,
    output logic        WUnalExc
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][7:0] lane_rdata;
    logic [NUM_LANES-1:0][7:0] lane_wdata;
    logic [NUM_LANES-1:0]      lane_we;
    logic [31:0]               rword;
    logic [15:0]               rhalf;
    logic [7:0]                rbyte;
    logic                      unused_addr_bits;

    // Size encoding: 00 byte, 01 half, 1x word.
    always_comb begin
        RUnalExc = 1'b0;
        WUnalExc = 1'b0;
        case (RWHBS)
            2'b00:   RUnalExc = 1'b0;
            2'b01:   RUnalExc = RADDR[0];
            default: RUnalExc = |RADDR[1:0];
        endcase
        case (WWHBS)
            2'b00:   WUnalExc = 1'b0;
            2'b01:   WUnalExc = WADDR[0];
            default: WUnalExc = |WADDR[1:0];
        endcase
    end

    always_comb begin
        lane_we = '0;
        case (WWHBS)
            2'b00:   lane_we = 4'b0001 << WADDR[1:0];
            2'b01:   lane_we = WADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_we = 4'b1111;
        endcase
        if (!WE || WUnalExc) lane_we = '0;
    end

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            // Half and byte writes take their data from the low bits of DIN.
            always_comb begin
                lane_wdata[l] = DIN[l*8 +: 8];
                case (WWHBS)
                    2'b00:   lane_wdata[l] = DIN[7:0];
                    2'b01:   lane_wdata[l] = DIN[(l%2)*8 +: 8];
                    default: lane_wdata[l] = DIN[l*8 +: 8];
                endcase
            end

            ram_wbh_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
                .clk   (CLK),
                .rst_n (RSTn),
                .we    (lane_we[l]),
                .waddr (WADDR[AW+1:2]),
                .wdata (lane_wdata[l]),
                .raddr (RADDR[AW+1:2]),
                .rdata (lane_rdata[l])
            );
        end
    endgenerate

    assign rword = lane_rdata;
    assign rhalf = RADDR[1] ? rword[31:16] : rword[15:0];
    assign rbyte = lane_rdata[RADDR[1:0]];

    always_comb begin
        DOUT = rword;
        case (RWHBS)
`ifdef RAM_SIGNEXT_EN
            2'b00:   DOUT = {{24{rbyte[7]}}, rbyte};
            2'b01:   DOUT = {{16{rhalf[15]}}, rhalf};
`else
            2'b00:   DOUT = {24'b0, rbyte};
            2'b01:   DOUT = {16'b0, rhalf};
`endif
            default: DOUT = rword;
        endcase
        if (RUnalExc || !RSTn) DOUT = '0;
    end

    // Addresses wrap modulo the memory size.
    assign unused_addr_bits = ^{RADDR[31:AW+2], WADDR[31:AW+2]};
endmodule

// File: tb/tb_ram_wbh.sv
// Table-driven bench for ram_wbh plus hand sequences for same-address and reset corners.

module tb_ram_wbh;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic        WE;
    logic [1:0]  RWHBS, WWHBS;
    logic [31:0] RADDR, WADDR, DIN;
    logic [31:0] DOUT;
    logic        RUnalExc, WUnalExc;

    int tests = 0;
    int failed = 0;

    ram_wbh dut (
        .CLK(CLK), .RSTn(RSTn), .WE(WE), .RWHBS(RWHBS), .WWHBS(WWHBS),
        .RADDR(RADDR), .WADDR(WADDR), .DIN(DIN), .DOUT(DOUT),
        .RUnalExc(RUnalExc), .WUnalExc(WUnalExc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [1:0]  ws;
        logic [31:0] wa;
        logic [31:0] din;
        logic [1:0]  rs;
        logic [31:0] ra;
        logic [31:0] exp_d;
        logic        exp_ru;
        logic        exp_wu;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b11, W2 = 2'b10;

`ifdef RAM_SIGNEXT_EN
    localparam logic [31:0] EXP_B80   = 32'hFFFFFF80;
    localparam logic [31:0] EXP_H8001 = 32'hFFFF8001;
`else
    localparam logic [31:0] EXP_B80   = 32'h00000080;
    localparam logic [31:0] EXP_H8001 = 32'h00008001;
`endif

    task automatic add(input logic we, input logic [1:0] ws, input logic [31:0] wa,
                       input logic [31:0] din, input logic [1:0] rs, input logic [31:0] ra,
                       input logic [31:0] exp_d, input logic exp_ru, input logic exp_wu);
        vec_t v;
        v.we = we; v.ws = ws; v.wa = wa; v.din = din; v.rs = rs; v.ra = ra;
        v.exp_d = exp_d; v.exp_ru = exp_ru; v.exp_wu = exp_wu;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Each vector: write applied at the next edge, read sampled after that edge.
        add(0, W,  32'h000, 32'h0,        W,  32'h000, 32'h00000000, 0, 0);
        add(1, W,  32'h000, 32'h11111111, W,  32'h000, 32'h11111111, 0, 0);
        add(1, H,  32'h004, 32'h22222222, H,  32'h004, 32'h00002222, 0, 0);
        add(1, H,  32'h006, 32'h33333333, W,  32'h004, 32'h33332222, 0, 0);
        add(0, W,  32'h000, 32'h0,        H,  32'h006, 32'h00003333, 0, 0);
        add(1, B,  32'h008, 32'h44444444, B,  32'h008, 32'h00000044, 0, 0);
        add(1, B,  32'h009, 32'h55555555, H,  32'h008, 32'h00005544, 0, 0);
        add(1, B,  32'h00A, 32'h66666666, B,  32'h00A, 32'h00000066, 0, 0);
        add(1, B,  32'h00B, 32'h77777777, W,  32'h008, 32'h77665544, 0, 0);
        add(0, W,  32'h000, 32'h0,        H,  32'h00A, 32'h00007766, 0, 0);
        add(0, W,  32'h000, 32'h0,        H,  32'h005, 32'h00000000, 1, 0);
        add(0, W,  32'h000, 32'h0,        W,  32'h006, 32'h00000000, 1, 0);
        add(1, W,  32'h002, 32'hDEADBEEF, W,  32'h000, 32'h11111111, 0, 1);
        add(0, W,  32'h000, 32'h0,        W,  32'h004, 32'h33332222, 0, 0);
        add(0, W,  32'h000, 32'hFFFFFFFF, W,  32'h000, 32'h11111111, 0, 0);
        add(1, B,  32'h00C, 32'h00000080, B,  32'h00C, EXP_B80,      0, 0);
        add(1, H,  32'h010, 32'h00008001, H,  32'h010, EXP_H8001,    0, 0);
        add(1, W,  32'h414, 32'hCAFEF00D, W,  32'h014, 32'hCAFEF00D, 0, 0);
        add(1, W2, 32'h018, 32'hA5A5A5A5, W2, 32'h818, 32'hA5A5A5A5, 0, 0);
        add(1, H,  32'h01B, 32'h0000FFFF, W,  32'h018, 32'hA5A5A5A5, 0, 1);
        add(1, W2, 32'h01D, 32'h0,        B,  32'h009, 32'h00000055, 0, 1);

        RSTn = 1'b0; WE = 1'b0; RWHBS = W; WWHBS = W;
        RADDR = '0; WADDR = '0; DIN = '0;
        #1;
        chk("reset_dout", DOUT, 32'h0);
        chk("reset_runal", {31'b0, RUnalExc}, 32'h0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CLK);
            WE = vecs[i].we; WWHBS = vecs[i].ws; WADDR = vecs[i].wa; DIN = vecs[i].din;
            RWHBS = vecs[i].rs; RADDR = vecs[i].ra;
            #1;
            chk($sformatf("v%0d_wunal", i), {31'b0, WUnalExc}, {31'b0, vecs[i].exp_wu});
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_dout", i), DOUT, vecs[i].exp_d);
            chk($sformatf("v%0d_runal", i), {31'b0, RUnalExc}, {31'b0, vecs[i].exp_ru});
        end

        // Same-address read/write: old data before the edge, new data after.
        @(negedge CLK);
        WE = 1'b1; WWHBS = W; WADDR = 32'h01C; DIN = 32'h12345678;
        RWHBS = W; RADDR = 32'h01C;
        #1;
        chk("raw_before_edge", DOUT, 32'h00000000);
        @(posedge CLK);
        #1;
        chk("raw_after_edge", DOUT, 32'h12345678);

        // Reset mid-run clears contents asynchronously and blocks writes.
        @(negedge CLK);
        WE = 1'b0; RADDR = 32'h000;
        #1;
        chk("pre_reset_word0", DOUT, 32'h11111111);
        RSTn = 1'b0;
        #1;
        chk("async_reset_dout", DOUT, 32'h0);
        WE = 1'b1; WWHBS = W; WADDR = 32'h020; DIN = 32'hFEEDFACE;
        @(posedge CLK);
        @(negedge CLK);
        WE = 1'b0;
        RSTn = 1'b1;
        RADDR = 32'h020;
        #1;
        chk("write_blocked_in_reset", DOUT, 32'h0);
        RADDR = 32'h01C;
        #1;
        chk("cleared_after_reset", DOUT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
